lr35902_uart_tx_arb: RTL and testbench
======================================

Name: lr35902_uart_tx_arb

Overview:
Shared UART transmitter with a round-robin arbiter for one physical tx pin. Several byte sources in the uart_clk domain each present a byte with a toggle (seq/ack) handshake. Examples are the debug responder and a serial-link/printf port. The block grants one source at a time, serializes its byte as 8N1 and acknowledges it. Flow control is through tx_hold.

Parameters:
NUM_REQ, 2, number of requesters (2..8)
BAUD_DIV, 12, uart_clk cycles per bit (>=2)
GW, 1, grant index width; must satisfy 2**GW >= NUM_REQ

Ports:
uart_clk  in  1  sole clock; all logic on rising edge
reset  in  1  synchronous, active-low (0 = reset)
req_seq  in  NUM_REQ  per-requester toggle; req_seq[i] != req_ack[i] means byte i pending
req_data  in  8*NUM_REQ  byte of requester i at bits [8*i+7:8*i]; sampled only at grant
req_ack  out  NUM_REQ  per-requester ack toggle
tx_hold  in  1  1 = do not start a new frame (a frame in flight completes)
tx  out  1  serial line, idle high
busy  out  1  1 from grant cycle through last stop-bit cycle
grant  out  GW  index of requester owning the current or last frame

Behaviour:
- pending[i] = req_seq[i] ^ req_ack[i].
- Reset (reset==0 at a clock edge) sets:
  - tx=1, req_ack=0, busy=0, grant=0;
  - state=IDLE, internal last-served pointer last=NUM_REQ-1, so requester 0 wins first;
  - bit/sub counters to don't-care.
- Reset mid-frame truncates the frame: tx=1 from the next edge and no ack is issued. A requester whose seq is 1 is then pending again.
- States are IDLE, START, DATA, STOP.
- IDLE:
  - If any pending and tx_hold==0, pick the first pending index scanning last+1, last+2, ... with wrap modulo NUM_REQ.
  - On the same edge: grant<=idx, shift<=req_data[idx], tx<=0, busy<=1, sub<=0, state<=START.
  - Otherwise tx stays 1 and busy stays 0.
- START: tx=0. When sub==BAUD_DIV-1: tx<=shift[0], shift>>=1, bit<=0, sub<=0, state<=DATA. Otherwise sub+=1.
- DATA: LSB first. When sub==BAUD_DIV-1:
  - if bit==7: tx<=1, state<=STOP;
  - else tx<=next shift bit, bit+=1.
  - In both cases sub<=0.
- STOP: tx=1. When sub==BAUD_DIV-1:
  - req_ack[grant]<=~req_ack[grant] (toggle, not copy of seq);
  - last<=grant, busy<=0, state<=IDLE.
- Timing:
  - Each bit is exactly BAUD_DIV cycles on tx.
  - One frame occupies 10*BAUD_DIV cycles from the grant edge to the ack edge.
  - The ack toggle is visible the cycle after the final stop-bit cycle.
  - Back-to-back frames are separated by exactly 1 idle cycle (tx=1), because IDLE evaluates on the edge after the ack.
- req_data changes after grant do not affect the frame in flight.
- A requester must not toggle req_seq while pending. If it does, at most one ack is issued per completed frame, and pending parity decides whether it is re-served.
- tx_hold is sampled only in IDLE. Asserting it mid-frame has no effect on that frame.
- Simultaneous pending: strict round-robin. With all requesters continuously pending, grants cycle 0,1,...,NUM_REQ-1,0,...
- A request arriving on the same edge as another's ack is eligible at the following IDLE evaluation.
- grant holds its value while IDLE.

Test Plan:
- Reset: hold reset=0 for 3 cycles with req_seq=2'b11 -> tx=1, busy=0, req_ack=0, grant=0 throughout. Release -> grant=0 and tx falls on the first edge.
- Single byte: BAUD_DIV=12, req_seq[0] toggles with req_data[7:0]=0xA5 -> tx shows 0, then 1,0,1,0,0,1,0,1, then 1, each bit 12 cycles. req_ack[0] toggles 120 cycles after the grant edge; busy high exactly 120 cycles.
- Round-robin: both requesters pending continuously, bytes 0x11/0x22 -> frames 0x11,0x22,0x11,... with exactly 1 idle cycle between frames. grant alternates 0,1,0.
- Flow control: tx_hold=1 with requester 1 pending -> tx stays 1, busy stays 0. Drop tx_hold -> frame starts on the next edge. Raise tx_hold during the data bits -> the frame still completes and acks.
- Reset mid-frame: assert reset at DATA bit 3 -> tx=1 the next cycle, req_ack=0, no ack toggle. After release, requester 0 (seq=1) is re-served from its start bit.
- Data stability: change req_data[0] from 0x3C to 0xFF one cycle after grant -> 0x3C is transmitted.

Source files
------------

// File: rtl/lr35902_uart_tx_arb.sv
// Shared 8N1 UART transmitter with round-robin arbitration across byte
// sources that use a toggle (seq/ack) handshake. A single tx pin is shared;
// one requester is served per frame and acknowledged after its stop bit.
//
// Handshake: requester i owns req_seq[i], this block owns req_ack[i].
// A byte is pending while req_seq[i] != req_ack[i]. The requester flips
// req_seq[i] with req_data valid; the byte is sampled once at grant, and
// req_ack[i] is flipped on the edge that ends the stop bit. The requester
// must leave req_seq[i] alone until it sees req_ack[i] catch up.
module lr35902_uart_tx_arb #(
    parameter int NUM_REQ  = 2,
    parameter int BAUD_DIV = 12,
    parameter int GW       = 1
) (
    input  logic                 uart_clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_seq,
    input  logic [8*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]   req_ack,
    input  logic                 tx_hold,
    output logic                 tx,
    output logic                 busy,
    output logic [GW-1:0]        grant
);

    localparam int SW = $clog2(BAUD_DIV);
    localparam logic [SW-1:0] SUB_LAST = SW'(BAUD_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    // State is kept as a named enum so checkers can bind to it directly.
    state_t state;
    state_t state_next;

    logic [NUM_REQ-1:0] pending;
    logic [NUM_REQ-1:0] ack_q;
    logic [GW-1:0]      last;
    logic [GW-1:0]      grant_q;
    logic [GW-1:0]      pick;
    logic               pick_valid;
    logic [7:0]         pick_byte;
    logic [7:0]         shift;
    logic [2:0]         bit_cnt;
    logic [SW-1:0]      sub;
    logic               sub_done;
    logic               tx_q;
    logic               busy_q;
    logic               start_frame;

    assign pending     = req_seq ^ ack_q;
    assign sub_done    = (sub == SUB_LAST);
    assign start_frame = pick_valid && !tx_hold;

    // Round-robin pick: first pending index after the last one served.
    // Scanning from the farthest offset down lets the nearest one win.
    always_comb begin
        int      cand;
        logic [GW-1:0] cand_idx;
        cand       = 0;
        cand_idx   = '0;
        pick       = '0;
        pick_valid = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand     = (int'(last) + k) % NUM_REQ;
            cand_idx = GW'(cand);
            if (pending[cand_idx]) begin
                pick       = cand_idx;
                pick_valid = 1'b1;
            end
        end
    end

    // Byte of the selected requester, captured into the shifter at grant.
    always_comb begin
        pick_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick == GW'(i)) begin
                pick_byte = req_data[8*i +: 8];
            end
        end
    end

    // State register.
    always_ff @(posedge uart_clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: each bit lasts BAUD_DIV cycles, sub marks the end.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_frame) state_next = START;
            START:   if (sub_done) state_next = DATA;
            DATA:    if (sub_done && bit_cnt == 3'd7) state_next = STOP;
            STOP:    if (sub_done) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: shifter, counters, line level, grant/ack bookkeeping.
    always_ff @(posedge uart_clk) begin
        if (!reset) begin
            tx_q    <= 1'b1;
            ack_q   <= '0;
            busy_q  <= 1'b0;
            grant_q <= '0;
            last    <= GW'(NUM_REQ - 1);
            shift   <= '0;
            bit_cnt <= '0;
            sub     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_frame) begin
                        grant_q <= pick;
                        shift   <= pick_byte;
                        tx_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        sub     <= '0;
                    end
                end
                START: begin
                    if (sub_done) begin
                        tx_q    <= shift[0];
                        shift   <= {1'b0, shift[7:1]};
                        bit_cnt <= '0;
                        sub     <= '0;
                    end else begin
                        sub <= sub + SW'(1);
                    end
                end
                DATA: begin
                    if (sub_done) begin
                        sub <= '0;
                        if (bit_cnt == 3'd7) begin
                            tx_q <= 1'b1;
                        end else begin
                            tx_q    <= shift[0];
                            shift   <= {1'b0, shift[7:1]};
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        sub <= sub + SW'(1);
                    end
                end
                STOP: begin
                    if (sub_done) begin
                        // Toggle rather than copy seq, so one frame yields one ack.
                        ack_q[grant_q] <= ~ack_q[grant_q];
                        last           <= grant_q;
                        busy_q         <= 1'b0;
                        sub            <= '0;
                    end else begin
                        sub <= sub + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs are driven straight from registers.
    always_comb begin
        tx      = tx_q;
        busy    = busy_q;
        grant   = grant_q;
        req_ack = ack_q;
    end

endmodule

// File: tb/tb_lr35902_uart_tx_arb.sv
// Bench for lr35902_uart_tx_arb: randomized requests checked against a
// frame-level model (8N1 waveform per byte, round-robin order, ack toggles).
module tb_lr35902_uart_tx_arb;

    localparam int NUM_REQ = 2;
    localparam int BAUD    = 12;
    localparam int GW      = 1;
    localparam int FRAME   = 10 * BAUD;

    logic                 uart_clk = 1'b0;
    logic                 reset    = 1'b0;
    logic [NUM_REQ-1:0]   req_seq  = '0;
    logic [8*NUM_REQ-1:0] req_data = '0;
    logic [NUM_REQ-1:0]   req_ack;
    logic                 tx_hold  = 1'b0;
    logic                 tx;
    logic                 busy;
    logic [GW-1:0]        grant;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [NUM_REQ-1:0] exp_ack = '0;
    int                 last_served = NUM_REQ - 1;
    logic [7:0]         src_byte [NUM_REQ];

    // Frame monitor results
    bit                 mon_found;
    int                 mon_wait;
    int                 mon_busy_cnt;
    logic [GW-1:0]      mon_grant;
    logic [FRAME-1:0]   mon_tx;
    logic [NUM_REQ-1:0] mon_ack_pre;
    logic               mon_post_tx;
    logic               mon_post_busy;
    logic [NUM_REQ-1:0] mon_post_ack;

    lr35902_uart_tx_arb #(.NUM_REQ(NUM_REQ), .BAUD_DIV(BAUD), .GW(GW)) dut (
        .uart_clk (uart_clk),
        .reset    (reset),
        .req_seq  (req_seq),
        .req_data (req_data),
        .req_ack  (req_ack),
        .tx_hold  (tx_hold),
        .tx       (tx),
        .busy     (busy),
        .grant    (grant)
    );

    always #5 uart_clk = ~uart_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model ----------------
    // Line level s cycles after the grant edge for an 8N1 frame of byte b.
    function automatic logic exp_level(input logic [7:0] b, input int s);
        int bi;
        bi = s / BAUD;
        if (bi == 0) return 1'b0;
        if (bi >= 9) return 1'b1;
        return b[bi-1];
    endfunction

    function automatic int next_grant();
        logic [NUM_REQ-1:0] pend;
        pend = req_seq ^ exp_ack;
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (pend[(last_served + k) % NUM_REQ]) return (last_served + k) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int tx_errors(input logic [7:0] b);
        int n;
        n = 0;
        for (int s = 0; s < FRAME; s++) begin
            if (mon_tx[s] !== exp_level(b, s)) n++;
        end
        return n;
    endfunction

    // ---------------- drivers ----------------
    task automatic set_req(input int i, input logic [7:0] b);
        src_byte[i]         = b;
        req_data[8*i +: 8]  = b;
        req_seq[i]          = ~req_seq[i];
    endtask

    task automatic do_reset(input int n);
        reset   = 1'b0;
        req_seq = '0;
        tx_hold = 1'b0;
        repeat (n) @(negedge uart_clk);
        reset       = 1'b1;
        exp_ack     = '0;
        last_served = NUM_REQ - 1;
    endtask

    // Waits for busy, then records one full frame plus the cycle after it.
    task automatic run_frame(input int max_wait);
        mon_found    = 1'b0;
        mon_wait     = 0;
        mon_busy_cnt = 0;
        for (int w = 0; w <= max_wait; w++) begin
            @(negedge uart_clk);
            if (busy === 1'b1) begin
                mon_found = 1'b1;
                break;
            end
            mon_wait++;
        end
        if (!mon_found) return;
        mon_grant    = grant;
        mon_tx[0]    = tx;
        mon_busy_cnt = 1;
        for (int s = 1; s < FRAME; s++) begin
            @(negedge uart_clk);
            mon_tx[s] = tx;
            if (busy === 1'b1) mon_busy_cnt++;
            if (s == FRAME - 1) mon_ack_pre = req_ack;
        end
        @(negedge uart_clk);
        mon_post_tx   = tx;
        mon_post_busy = busy;
        mon_post_ack  = req_ack;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset    = 1'b0;
        req_seq  = 2'b11;
        req_data = 16'($urandom);
        for (int c = 0; c < 3; c++) begin
            @(negedge uart_clk);
            total++; if (tx !== 1'b1) begin bad++; $display("FAIL reset_tx: got %b want 1", tx); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
            total++; if (req_ack !== 2'b00) begin bad++; $display("FAIL reset_ack: got %b want 00", req_ack); end
            total++; if (grant !== 1'b0) begin bad++; $display("FAIL reset_grant: got %b want 0", grant); end
        end
        reset = 1'b1;
        @(negedge uart_clk);
        total++;
        if ({busy, tx, grant} !== 3'b100) begin
            bad++;
            $display("FAIL reset_release: busy/tx/grant got %b want 100", {busy, tx, grant});
        end
        do_reset(2);
    endtask

    task automatic test_single();
        logic [NUM_REQ-1:0] pre;
        int n;
        set_req(0, 8'hA5);
        pre = exp_ack;
        run_frame(5);
        total++; if (!mon_found) begin bad++; $display("FAIL single_start: no frame seen want frame"); return; end
        total++; if (mon_grant !== 1'b0) begin bad++; $display("FAIL single_grant: got %0d want 0", mon_grant); end
        n = tx_errors(8'hA5);
        total++; if (n !== 0) begin bad++; $display("FAIL single_bits: bit errors=%0d want 0", n); end
        total++; if (mon_busy_cnt !== FRAME) begin bad++; $display("FAIL single_busy_len: got %0d want %0d", mon_busy_cnt, FRAME); end
        total++; if (mon_ack_pre !== pre) begin bad++; $display("FAIL single_ack_early: got %b want %b", mon_ack_pre, pre); end
        exp_ack[0]  = ~exp_ack[0];
        last_served = 0;
        total++; if (mon_post_ack !== exp_ack) begin bad++; $display("FAIL single_ack: got %b want %b", mon_post_ack, exp_ack); end
        total++; if ({mon_post_busy, mon_post_tx} !== 2'b01) begin bad++; $display("FAIL single_idle: busy/tx got %b want 01", {mon_post_busy, mon_post_tx}); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_seq[i] == exp_ack[i] && $urandom_range(0, 1) == 1) set_req(i, 8'($urandom));
            end
            if (next_grant() < 0) set_req(r % NUM_REQ, 8'($urandom));
            while (next_grant() >= 0) begin
                int eg;
                int n;
                logic [7:0] eb;
                eg = next_grant();
                eb = src_byte[eg];
                run_frame(5);
                total++; if (!mon_found) begin bad++; $display("FAIL rand_start: no frame seen want frame"); return; end
                total++; if (mon_grant !== GW'(eg)) begin bad++; $display("FAIL rand_grant: got %0d want %0d", mon_grant, eg); end
                n = tx_errors(eb);
                total++; if (n !== 0) begin bad++; $display("FAIL rand_bits: byte %h bit errors=%0d want 0", eb, n); end
                exp_ack[eg] = ~exp_ack[eg];
                last_served = eg;
                total++; if (mon_post_ack !== exp_ack) begin bad++; $display("FAIL rand_ack: got %b want %b", mon_post_ack, exp_ack); end
            end
        end
    endtask

    task automatic test_back_to_back();
        int prev_g;
        prev_g = -1;
        set_req(0, 8'h11);
        set_req(1, 8'h22);
        for (int f = 0; f < 4; f++) begin
            int eg;
            int n;
            eg = next_grant();
            run_frame(5);
            total++; if (!mon_found) begin bad++; $display("FAIL b2b_start: no frame seen want frame"); return; end
            total++; if (mon_grant !== GW'(eg) || eg == prev_g) begin bad++; $display("FAIL b2b_grant: got %0d want %0d", mon_grant, eg); end
            n = tx_errors(src_byte[eg]);
            total++; if (n !== 0) begin bad++; $display("FAIL b2b_bits: bit errors=%0d want 0", n); end
            if (f > 0) begin
                total++; if (mon_wait !== 0) begin bad++; $display("FAIL b2b_gap: extra idle cycles=%0d want 0", mon_wait); end
            end
            exp_ack[eg] = ~exp_ack[eg];
            last_served = eg;
            prev_g      = eg;
            total++; if (mon_post_ack !== exp_ack) begin bad++; $display("FAIL b2b_ack: got %b want %b", mon_post_ack, exp_ack); end
            if (f < 2) set_req(eg, src_byte[eg]);
        end
    endtask

    task automatic test_flow();
        int viol;
        int n;
        logic [7:0] b;
        b       = 8'($urandom);
        tx_hold = 1'b1;
        set_req(1, b);
        viol = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge uart_clk);
            if (tx !== 1'b1 || busy !== 1'b0) viol++;
        end
        total++; if (viol !== 0) begin bad++; $display("FAIL hold_idle: violating cycles=%0d want 0", viol); end
        tx_hold = 1'b0;
        fork
            run_frame(3);
            begin
                repeat (60) @(negedge uart_clk);
                tx_hold = 1'b1;
            end
        join
        total++; if (!mon_found || mon_wait !== 0) begin bad++; $display("FAIL hold_release: found=%0d wait=%0d want 1/0", mon_found, mon_wait); end
        total++; if (mon_grant !== 1'b1) begin bad++; $display("FAIL hold_grant: got %0d want 1", mon_grant); end
        n = tx_errors(b);
        total++; if (n !== 0) begin bad++; $display("FAIL hold_bits: bit errors=%0d want 0", n); end
        exp_ack[1]  = ~exp_ack[1];
        last_served = 1;
        total++; if (mon_post_ack !== exp_ack) begin bad++; $display("FAIL hold_ack: got %b want %b", mon_post_ack, exp_ack); end
        tx_hold = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit seen;
        int n;
        logic [7:0] b;
        @(negedge uart_clk);
        do_reset(2);
        b = 8'($urandom);
        set_req(0, b);
        seen = 1'b0;
        for (int w = 0; w < 5; w++) begin
            @(negedge uart_clk);
            if (busy === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        total++; if (!seen) begin bad++; $display("FAIL mid_start: no frame seen want frame"); return; end
        repeat (50) @(negedge uart_clk);
        reset = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge uart_clk);
            total++;
            if ({tx, busy, req_ack} !== 4'b1000) begin
                bad++;
                $display("FAIL mid_reset: tx/busy/ack got %b want 1000", {tx, busy, req_ack});
            end
        end
        reset       = 1'b1;
        exp_ack     = '0;
        last_served = NUM_REQ - 1;
        run_frame(3);
        total++; if (!mon_found || mon_wait !== 0) begin bad++; $display("FAIL mid_reserve: found=%0d wait=%0d want 1/0", mon_found, mon_wait); end
        total++; if (mon_grant !== 1'b0) begin bad++; $display("FAIL mid_grant: got %0d want 0", mon_grant); end
        n = tx_errors(b);
        total++; if (n !== 0) begin bad++; $display("FAIL mid_bits: bit errors=%0d want 0", n); end
        exp_ack[0]  = ~exp_ack[0];
        last_served = 0;
        total++; if (mon_post_ack !== exp_ack) begin bad++; $display("FAIL mid_ack: got %b want %b", mon_post_ack, exp_ack); end
    endtask

    task automatic test_data_stable();
        int n;
        set_req(0, 8'h3C);
        fork
            run_frame(3);
            begin
                for (int w = 0; w < 5; w++) begin
                    @(negedge uart_clk);
                    if (busy === 1'b1) break;
                end
                @(negedge uart_clk);
                req_data[7:0] = 8'hFF;
            end
        join
        total++; if (!mon_found) begin bad++; $display("FAIL stable_start: no frame seen want frame"); return; end
        n = tx_errors(8'h3C);
        total++; if (n !== 0) begin bad++; $display("FAIL stable_bits: bit errors=%0d want 0 (byte 3c)", n); end
        exp_ack[0]  = ~exp_ack[0];
        last_served = 0;
        total++; if (mon_post_ack !== exp_ack) begin bad++; $display("FAIL stable_ack: got %b want %b", mon_post_ack, exp_ack); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_random();
        test_back_to_back();
        test_flow();
        test_reset_mid();
        test_data_stable();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
